// File: rtl/dpram_port_arbiter.sv
// Two-port front end for a single-port RAM: picks one requester per cycle,
// with optional bounded burst locking, and routes read data back to its port.
module dpram_port_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          b_gnt,
  output logic          a_rvalid,
  output logic          b_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic [DW-1:0] b_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  port_e         last_grant_q, last_grant_d;
  logic [3:0]    burst_cnt_q, burst_cnt_d;
  logic          s1_valid_q, s1_valid_d;
  port_e         s1_port_q, s1_port_d;
  logic          s2_valid_q, s2_valid_d;
  port_e         s2_port_q, s2_port_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          grant_a, grant_b;
  logic          owner_keeps;

  // Owner keeps a contested grant only while locked and under the burst limit.
  always_comb begin
    grant_a     = 1'b0;
    grant_b     = 1'b0;
    owner_keeps = ((last_grant_q == PORT_A) ? a_lock : b_lock) &&
                  (burst_cnt_q < BURST_MAX);
    if (!rst) begin
      if (a_req && b_req) begin
        if (last_grant_q == PORT_A) begin
          grant_a = owner_keeps;
          grant_b = !owner_keeps;
        end else begin
          grant_b = owner_keeps;
          grant_a = !owner_keeps;
        end
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  assign a_gnt     = grant_a;
  assign b_gnt     = grant_b;
  assign ram_en    = grant_a || grant_b;
  assign ram_we    = grant_a ? a_we : (grant_b ? b_we : 1'b0);
  assign ram_addr  = grant_b ? b_addr : a_addr;
  assign ram_wdata = grant_b ? b_wdata : a_wdata;

  always_comb begin
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    if (grant_a || grant_b) begin
      last_grant_d = grant_a ? PORT_A : PORT_B;
      if (last_grant_d != last_grant_q) begin
        burst_cnt_d = 4'd1;
      end else if (burst_cnt_q < BURST_MAX) begin
        burst_cnt_d = burst_cnt_q + 4'd1;
      end
    end
    s1_valid_d = ram_en && !ram_we;
    s1_port_d  = grant_b ? PORT_B : PORT_A;
    s2_valid_d = s1_valid_q;
    s2_port_d  = s1_port_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    if (s1_valid_q) begin
      if (s1_port_q == PORT_A) begin
        a_rdata_d = ram_rdata;
      end else begin
        b_rdata_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= PORT_B;
      burst_cnt_q  <= '0;
      s1_valid_q   <= 1'b0;
      s1_port_q    <= PORT_A;
      s2_valid_q   <= 1'b0;
      s2_port_q    <= PORT_A;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_port_q    <= s1_port_d;
      s2_valid_q   <= s2_valid_d;
      s2_port_q    <= s2_port_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

  // Masked by rst so a pulse already in the last stage never escapes.
  assign a_rvalid = s2_valid_q && (s2_port_q == PORT_A) && !rst;
  assign b_rvalid = s2_valid_q && (s2_port_q == PORT_B) && !rst;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Scoreboard bench: the driver predicts grants and read results from an
// abstract model of the arbitration rules and memory; a monitor checks returns.
module tb_dpram_port_arbiter;

  localparam int AW        = 8;
  localparam int DW        = 16;
  localparam int MAX_BURST = 4;

  logic          clk;
  logic          rst;
  logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr, ram_addr;
  logic [DW-1:0] a_wdata, b_wdata, ram_wdata, ram_rdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_en, ram_we;
  logic [DW-1:0] a_rdata, b_rdata;

  dpram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input int i);
    logic [DW-1:0] v;
    v = DW'(i * 263);
    return v ^ 16'hA5C3;
  endfunction

  // Environment RAM attached to the DUT's RAM port.
  logic          mem_init;
  logic [DW-1:0] env_ram [0:255];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_ram[i] <= init_val(i);
    end else if (ram_en) begin
      if (ram_we) env_ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= env_ram[ram_addr];
    end
  end

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_mem [0:255];
  logic          m_owner;
  int            m_streak;
  int            a_wait, b_wait;
  int            checks = 0;
  int            passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic step(input logic r,
                      input logic ar, input logic aw, input logic al,
                      input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic br, input logic bw, input logic bl,
                      input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    logic [1:0]    g_exp;
    logic          owner_lock, gp, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    @(posedge clk);
    #1;
    rst = r;
    a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    #1;
    g_exp = 2'b00;
    if (r) begin
      exp_q.delete();
      m_owner  = 1'b1;
      m_streak = 0;
    end else if (ar && br) begin
      owner_lock = m_owner ? bl : al;
      if (owner_lock && m_streak < MAX_BURST) g_exp = m_owner ? 2'b10 : 2'b01;
      else                                    g_exp = m_owner ? 2'b01 : 2'b10;
    end else if (ar) begin
      g_exp = 2'b01;
    end else if (br) begin
      g_exp = 2'b10;
    end
    chk("grant", {30'd0, b_gnt, a_gnt}, {30'd0, g_exp});
    if (g_exp != 2'b00) begin
      gp   = g_exp[1];
      we   = gp ? bw : aw;
      addr = gp ? ba : aa;
      wd   = gp ? bd : ad;
      chk("ram_en", ram_en, 1);
      chk("ram_we", ram_we, we);
      chk("ram_addr", ram_addr, addr);
      if (we) begin
        chk("ram_wdata", ram_wdata, wd);
        m_mem[addr] = wd;
      end else begin
        exp_q.push_back('{port: gp, data: m_mem[addr], due: cyc + 2});
      end
      if (gp == m_owner) m_streak = (m_streak < MAX_BURST) ? m_streak + 1 : m_streak;
      else               m_streak = 1;
      m_owner = gp;
    end else begin
      chk("ram_idle", {ram_en, ram_we}, 0);
    end
    if (!r && ar && !a_gnt) a_wait++; else a_wait = 0;
    if (!r && br && !b_gnt) b_wait++; else b_wait = 0;
    chk("wait_bound", (a_wait <= MAX_BURST + 1) && (b_wait <= MAX_BURST + 1), 1);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
  endtask

  // Monitor: every cycle the front of the queue says which rvalid, if any, is due.
  initial begin
    logic exp_a, exp_b;
    forever begin
      @(negedge clk);
      exp_a = 1'b0;
      exp_b = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        if (exp_q[0].port) exp_b = 1'b1;
        else               exp_a = 1'b1;
      end
      chk("a_rvalid", a_rvalid, exp_a);
      chk("b_rvalid", b_rvalid, exp_b);
      if (exp_a) chk("a_rdata", a_rdata, exp_q[0].data);
      if (exp_b) chk("b_rdata", b_rdata, exp_q[0].data);
      if (exp_a || exp_b) void'(exp_q.pop_front());
    end
  end

  initial begin
    logic [9:0] burst_pat;
    rst = 1'b1; mem_init = 1'b1;
    a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_lock = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
    m_owner = 1'b1; m_streak = 0; a_wait = 0; b_wait = 0;

    // Reset with both ports requesting: nothing may be granted.
    step(1, 1, 0, 0, 8'h01, '0, 1, 0, 0, 8'h02, '0);
    mem_init = 1'b0;
    step(1, 1, 1, 1, 8'h03, 16'hFFFF, 1, 1, 1, 8'h04, 16'hEEEE);
    idle();
    chk("reset_a_rdata", a_rdata, 0);
    chk("reset_b_rdata", b_rdata, 0);

    // Unlocked tie: strict alternation starting with A.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0, AW'(i), '0, 1, 0, 0, AW'(16 + i), '0);
      chk("alt_grant", {b_gnt, a_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
    end

    // A locked against a contending B: four A grants, then B.
    burst_pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 1, AW'(32 + i), '0, 1, 0, 0, AW'(48 + i), '0);
      chk("burst_pattern", {b_gnt, a_gnt}, burst_pat[i] ? 2'b10 : 2'b01);
    end

    // Sole locked requester is never cut off.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 1, AW'(64 + i), '0, 0, 0, 0, '0, '0);
      chk("sole_a_gnt", a_gnt, 1);
      chk("sole_b_gnt", b_gnt, 0);
    end

    // Write from A visible to B's read in the very next cycle.
    step(0, 1, 1, 0, 8'h05, 16'h1234, 0, 0, 0, '0, '0);
    step(0, 0, 0, 0, '0, '0, 1, 0, 0, 8'h05, '0);
    idle();
    idle();
    chk("wr_then_rd", b_rdata, 16'h1234);

    // Read in flight when reset hits is dropped.
    step(0, 1, 0, 0, 8'h05, '0, 0, 0, 0, '0, '0);
    step(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    idle();
    idle();
    chk("flush_a_rdata", a_rdata, 0);
    step(0, 1, 0, 0, 8'h07, '0, 1, 0, 0, 8'h08, '0);
    chk("post_reset_tie", {b_gnt, a_gnt}, 2'b01);

    for (int n = 0; n < 10000; n++) begin
      step($urandom_range(0, 999) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 15)), DW'($urandom),
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 15)), DW'($urandom));
    end

    for (int i = 0; i < 4; i++) idle();
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
